// File: rtl/ccu_clkreq_pkg.sv
// Shared state encoding, default timing constants and timer sizing for the
// per-slice clkreq/clkack sequencer.
package ccu_clkreq_pkg;

   typedef enum logic [2:0] {
      OFF    = 3'd0,
      REQ_UP = 3'd1,
      ON     = 3'd2,
      HYST   = 3'd3,
      REQ_DN = 3'd4
   } ccu_clkreq_state_t;

   localparam int DEF_NUM_SLICES  = 7;
   localparam int DEF_HYST_CYC    = 16;
   localparam int DEF_ACK_TIMEOUT = 64;
   localparam int DEF_RST_DLY     = 8;
   localparam int DEF_SYNC_STAGES = 2;

   // One width shared by the ack, hysteresis and reset-release timers.
   function automatic int tmr_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ccu_clkreq_slice_fsm.sv
// One clock slice: clkack synchronizer, four-phase handshake FSM, ack/hysteresis/
// reset-release timers and the registered clkreq, clk_on, slice_rst_b, err flags.
module ccu_clkreq_slice_fsm
   import ccu_clkreq_pkg::*;
#(
   parameter int HYST_CYC    = DEF_HYST_CYC,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int RST_DLY     = DEF_RST_DLY,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_wake,
   input  logic i_clkack,
   output logic o_clkreq,
   output logic o_clk_on,
   output logic o_slice_rst_b,
   output logic o_err_timeout
);

   localparam int TW = tmr_width(ACK_TIMEOUT, HYST_CYC, RST_DLY);
   localparam logic [TW-1:0] ACK_T  = TW'(ACK_TIMEOUT);
   localparam logic [TW-1:0] HYST_T = TW'(HYST_CYC);
   localparam logic [TW-1:0] RST_T  = TW'(RST_DLY);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   ccu_clkreq_state_t      r_state;
   logic [TW-1:0]          r_tmr;
   logic [TW-1:0]          r_hcnt;
   logic [TW-1:0]          r_rcnt;
   logic                   r_clkreq;
   logic                   r_clk_on;
   logic                   r_rst_b;
   logic                   r_err;

   logic                   w_ack_s;
   logic                   w_sync_vld;
   ccu_clkreq_state_t      w_state_next;
   logic [TW-1:0]          w_tmr_next;
   logic [TW-1:0]          w_hcnt_next;
   logic [TW-1:0]          w_rcnt_next;
   logic                   w_tmr_run;
   logic                   w_rst_rel;

   // r_vld marks when ack_s reflects a post-reset sample of clkack, so a stale
   // ack held across reset is seen before OFF may raise a new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_vld  <= '0;
      end else begin
         r_sync[0] <= i_clkack;
         r_vld[0]  <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
            r_vld[i]  <= r_vld[i-1];
         end
      end
   end

   assign w_ack_s    = r_sync[SYNC_STAGES-1];
   assign w_sync_vld = r_vld[SYNC_STAGES-1];

   always_comb begin
      w_state_next = r_state;
      w_hcnt_next  = r_hcnt;
      case (r_state)
         OFF: begin
            if (i_wake && !w_ack_s && w_sync_vld) w_state_next = REQ_UP;
         end
         REQ_UP: begin
            if (w_ack_s) w_state_next = ON;
         end
         ON: begin
            if (!i_wake) begin
               if (HYST_CYC == 0) begin
                  w_state_next = REQ_DN;
               end else begin
                  w_state_next = HYST;
                  w_hcnt_next  = HYST_T;
               end
            end
         end
         HYST: begin
            if (i_wake) begin
               w_state_next = ON;
               w_hcnt_next  = '0;
            end else if (r_hcnt <= TW'(1)) begin
               w_state_next = REQ_DN;
               w_hcnt_next  = '0;
            end else begin
               w_hcnt_next  = r_hcnt - 1'b1;
            end
         end
         REQ_DN: begin
            if (!w_ack_s) w_state_next = OFF;
         end
         default: w_state_next = OFF;
      endcase
   end

   // Ack timer restarts on every state change and saturates at the timeout.
   always_comb begin
      w_tmr_run  = (w_state_next == r_state) && ((r_state == REQ_UP) || (r_state == REQ_DN));
      w_tmr_next = '0;
      if (w_tmr_run) w_tmr_next = (r_tmr >= ACK_T) ? r_tmr : r_tmr + 1'b1;
      w_rcnt_next = r_rcnt;
      if ((r_state == ON) && (r_rcnt < RST_T)) w_rcnt_next = r_rcnt + 1'b1;
      w_rst_rel = ((r_state == ON) || (w_state_next == ON)) && (w_rcnt_next >= RST_T);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= OFF;
         r_tmr    <= '0;
         r_hcnt   <= '0;
         r_rcnt   <= '0;
         r_clkreq <= 1'b0;
         r_clk_on <= 1'b0;
         r_rst_b  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_tmr    <= w_tmr_next;
         r_hcnt   <= w_hcnt_next;
         r_rcnt   <= w_rcnt_next;
         r_clkreq <= (w_state_next == REQ_UP) || (w_state_next == ON) || (w_state_next == HYST);
         r_clk_on <= (w_state_next == ON) || (w_state_next == HYST);
         r_rst_b  <= r_rst_b | w_rst_rel;
         r_err    <= r_err | (w_tmr_run && (w_tmr_next >= ACK_T));
      end
   end

   assign o_clkreq      = r_clkreq;
   assign o_clk_on      = r_clk_on;
   assign o_slice_rst_b = r_rst_b;
   assign o_err_timeout = r_err;

endmodule

// File: rtl/ccu_clkreq_seq.sv
// Clock-request sequencer toward the CCU: NUM_SLICES fully independent slice
// handshake engines, no arbitration between them.
module ccu_clkreq_seq
   import ccu_clkreq_pkg::*;
#(
   parameter int NUM_SLICES  = DEF_NUM_SLICES,
   parameter int HYST_CYC    = DEF_HYST_CYC,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int RST_DLY     = DEF_RST_DLY,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SLICES-1:0] wake,
   input  logic [NUM_SLICES-1:0] clkack,
   output logic [NUM_SLICES-1:0] clkreq,
   output logic [NUM_SLICES-1:0] clk_on,
   output logic [NUM_SLICES-1:0] slice_rst_b,
   output logic [NUM_SLICES-1:0] err_timeout
);

   for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      ccu_clkreq_slice_fsm #(
         .HYST_CYC    (HYST_CYC),
         .ACK_TIMEOUT (ACK_TIMEOUT),
         .RST_DLY     (RST_DLY),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_fsm (
         .clk           (clk),
         .rst           (rst),
         .i_wake        (wake[gi]),
         .i_clkack      (clkack[gi]),
         .o_clkreq      (clkreq[gi]),
         .o_clk_on      (clk_on[gi]),
         .o_slice_rst_b (slice_rst_b[gi]),
         .o_err_timeout (err_timeout[gi])
      );
   end

endmodule

// File: tb/tb_ccu_clkreq_seq.sv
// Scenario bench for ccu_clkreq_seq: per-slice CCU ack agents, expected output
// edges queued at stimulus time and matched against the cycle they appear.
module tb_ccu_clkreq_seq;

   localparam int NS = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NS-1:0] wake = '0;
   logic [NS-1:0] man_ack = '0;
   logic [NS-1:0] agent_en = '0;
   logic [NS-1:0] seen_on = '0;
   wire  [NS-1:0] clkack;
   wire  [NS-1:0] clkreq;
   wire  [NS-1:0] clk_on;
   wire  [NS-1:0] slice_rst_b;
   wire  [NS-1:0] err_timeout;

   int up_dly [NS];
   int dn_dly [NS];
   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int   idx;
      int   sel;
      logic lvl;
      int   cyc;
      int   obs;
   } exp_t;

   exp_t exp_q [$];
   exp_t done_q[$];

   ccu_clkreq_seq dut (
      .clk         (clk),
      .rst         (rst),
      .wake        (wake),
      .clkack      (clkack),
      .clkreq      (clkreq),
      .clk_on      (clk_on),
      .slice_rst_b (slice_rst_b),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CCU agent per slice: follows clkreq after up/down delays, or passes man_ack.
   for (genvar gi = 0; gi < NS; gi++) begin : g_agent
      logic ack_q = 1'b0;
      int   cnt   = 0;
      assign clkack[gi] = agent_en[gi] ? ack_q : man_ack[gi];
      initial begin
         forever begin
            @(negedge clk);
            if (!agent_en[gi]) begin
               ack_q = man_ack[gi];
               cnt   = 0;
            end else if (clkreq[gi] != ack_q) begin
               cnt++;
               if (cnt > (clkreq[gi] ? up_dly[gi] : dn_dly[gi])) begin
                  ack_q = clkreq[gi];
                  cnt   = 0;
               end
            end else begin
               cnt = 0;
            end
         end
      end
   end

   function automatic logic sig(input int sel, input int idx);
      case (sel)
         0:       return clkreq[idx];
         1:       return clk_on[idx];
         2:       return slice_rst_b[idx];
         default: return err_timeout[idx];
      endcase
   endfunction

   function automatic string nm(input int sel);
      case (sel)
         0:       return "clkreq";
         1:       return "clk_on";
         2:       return "slice_rst_b";
         default: return "err_timeout";
      endcase
   endfunction

   task automatic push(input int idx, input int sel, input logic lvl, input int at);
      exp_t e;
      e.idx = idx; e.sel = sel; e.lvl = lvl; e.cyc = at; e.obs = -1;
      exp_q.push_back(e);
   endtask

   // Moves each expected edge to done_q with the cycle it was observed (-1 if never).
   task automatic collect(input int budget);
      exp_t e;
      for (int n = 0; n <= budget && exp_q.size() > 0; n++) begin
         for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (sig(exp_q[k].sel, exp_q[k].idx) === exp_q[k].lvl) begin
               e = exp_q[k];
               e.obs = cyc;
               done_q.push_back(e);
               exp_q.delete(k);
            end
         end
         if (exp_q.size() > 0) @(negedge clk);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         done_q.push_back(e);
      end
   endtask

   task automatic quiesce();
      int n;
      wake = '0;
      for (int i = 0; i < NS; i++) begin
         up_dly[i] = 3;
         dn_dly[i] = 2;
      end
      @(negedge clk);
      agent_en = '1;
      n = 0;
      while (n < 150 && (clkreq !== '0 || clkack !== '0)) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (clkreq !== '0 || clkack !== '0) begin
         bad++;
         $display("FAIL quiesce clkreq=%b clkack=%b, required all 0", clkreq, clkack);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({clkreq, clk_on, slice_rst_b, err_timeout} !== '0) begin
         bad++;
         $display("FAIL reset_hold req=%b on=%b rstb=%b err=%b, required all 0",
                  clkreq, clk_on, slice_rst_b, err_timeout);
      end else $display("reset: all outputs 0");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({clkreq, clk_on, slice_rst_b, err_timeout} !== '0) begin
         bad++;
         $display("FAIL reset_idle req=%b on=%b rstb=%b err=%b, required all 0",
                  clkreq, clk_on, slice_rst_b, err_timeout);
      end else $display("post-reset idle: all outputs 0");
   endtask

   task automatic test_wake_on();
      int w;
      exp_t e;
      up_dly[0] = 3;
      dn_dly[0] = 30;
      agent_en[0] = 1'b1;
      @(negedge clk);
      w = cyc;
      wake[0] = 1'b1;
      push(0, 0, 1'b1, w + 1);
      push(0, 1, 1'b1, w + 7);
      push(0, 2, 1'b1, w + 15);
      seen_on[0] = 1'b1;
      collect(40);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL wake_on %s[%0d] rose at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("wake_on %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
   endtask

   task automatic test_hysteresis();
      int d;
      int errs;
      exp_t e;
      @(negedge clk);
      wake[0] = 1'b0;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 10) wake[0] = 1'b1;
         @(negedge clk);
         if (clkreq[0] !== 1'b1 || clk_on[0] !== 1'b1) errs++;
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL hyst_short clkreq/clk_on dropped in %0d cycles, required 0", errs);
      end else $display("hyst_short: clkreq held through 10-cycle idle");
      @(negedge clk);
      d = cyc;
      wake[0] = 1'b0;
      push(0, 0, 1'b0, d + 17);
      push(0, 1, 1'b0, d + 17);
      collect(30);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL hyst_long %s[%0d] fell at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("hyst_long %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
   endtask

   task automatic test_wake_in_req_dn();
      int f;
      exp_t e;
      f = cyc;
      @(negedge clk);
      @(negedge clk);
      wake[0] = 1'b1;
      // agent drops ack 30 cycles after clkreq fell at f
      push(0, 0, 1'b1, f + 34);
      push(0, 1, 1'b1, f + 40);
      collect(60);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL req_dn_wake %s[%0d] rose at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("req_dn_wake %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
   endtask

   task automatic test_timeout();
      int w;
      exp_t e;
      agent_en[3] = 1'b0;
      man_ack[3]  = 1'b0;
      @(negedge clk);
      w = cyc;
      wake[3] = 1'b1;
      push(3, 0, 1'b1, w + 1);
      push(3, 3, 1'b1, w + 65);
      collect(80);
      while (cyc < w + 200) @(negedge clk);
      total++;
      if (clkreq[3] !== 1'b1 || clk_on[3] !== 1'b0) begin
         bad++;
         $display("FAIL timeout_hold clkreq=%b clk_on=%b, required 1/0", clkreq[3], clk_on[3]);
      end else $display("timeout_hold: clkreq[3] held while waiting");
      man_ack[3] = 1'b1;
      push(3, 1, 1'b1, w + 203);
      push(3, 2, 1'b1, w + 211);
      seen_on[3] = 1'b1;
      collect(20);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL timeout %s[%0d] at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("timeout %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
      total++;
      if (err_timeout !== 7'b0001000) begin
         bad++;
         $display("FAIL timeout_sticky err_timeout=%b, required 0001000", err_timeout);
      end else $display("timeout_sticky: err_timeout[3] stays set after late ack");
   endtask

   task automatic test_all_slices();
      int w;
      exp_t e;
      quiesce();
      for (int i = 0; i < NS; i++) up_dly[i] = $urandom_range(1, 40);
      @(negedge clk);
      w = cyc;
      wake = '1;
      for (int i = 0; i < NS; i++) begin
         push(i, 0, 1'b1, w + 1);
         push(i, 1, 1'b1, w + 4 + up_dly[i]);
         if (!seen_on[i]) push(i, 2, 1'b1, w + 12 + up_dly[i]);
         seen_on[i] = 1'b1;
      end
      collect(80);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL all_slices %s[%0d] at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("all_slices %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
      total++;
      if (err_timeout !== 7'b0001000) begin
         bad++;
         $display("FAIL all_slices_err err_timeout=%b, required 0001000", err_timeout);
      end else $display("all_slices: no new timeouts");
   endtask

   task automatic test_reset_mid();
      int w;
      int errs;
      exp_t e;
      quiesce();
      agent_en[5] = 1'b0;
      man_ack[5]  = 1'b0;
      @(negedge clk);
      w = cyc;
      wake[2] = 1'b1;
      wake[5] = 1'b1;
      push(2, 1, 1'b1, w + 7);
      push(5, 0, 1'b1, w + 1);
      collect(30);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL rst_setup %s[%0d] at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("rst_setup %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
      man_ack[2] = 1'b1;
      @(negedge clk);
      agent_en[2] = 1'b0;
      @(negedge clk);
      wake[2] = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({clkreq[2], clk_on[2], clkreq[5], clk_on[5]} !== 4'b1110) begin
         bad++;
         $display("FAIL rst_pre req2=%b on2=%b req5=%b on5=%b, required 1 1 1 0",
                  clkreq[2], clk_on[2], clkreq[5], clk_on[5]);
      end else $display("rst_pre: slice 2 in hysteresis, slice 5 requesting");
      rst  = 1'b1;
      wake = 7'b0000100;
      #1;
      total++;
      if ({clkreq, clk_on, slice_rst_b, err_timeout} !== '0) begin
         bad++;
         $display("FAIL rst_async req=%b on=%b rstb=%b err=%b, required all 0",
                  clkreq, clk_on, slice_rst_b, err_timeout);
      end else $display("rst_async: all outputs cleared immediately");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (clkreq !== '0) errs++;
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL rst_stale_ack clkreq raised in %0d cycles with ack high, required 0", errs);
      end else $display("rst_stale_ack: slice 2 holds OFF while clkack stays 1");
      w = cyc;
      man_ack[2] = 1'b0;
      push(2, 0, 1'b1, w + 3);
      collect(20);
      while (done_q.size() > 0) begin
         e = done_q.pop_front();
         total++;
         if (e.obs !== e.cyc) begin
            bad++;
            $display("FAIL rst_rereq %s[%0d] at cycle %0d, required %0d", nm(e.sel), e.idx, e.obs, e.cyc);
         end else $display("rst_rereq %s[%0d] -> %0b at cycle %0d", nm(e.sel), e.idx, e.lvl, e.obs);
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         up_dly[i] = 3;
         dn_dly[i] = 2;
      end
      test_reset();
      test_wake_on();
      test_hysteresis();
      test_wake_in_req_dn();
      test_timeout();
      test_all_slices();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ccu_clkreq_seq.md
Name: ccu_clkreq_seq

Overview:
Per-slice clock-request sequencer that drives the four-phase clkreq/clkack handshake toward the CCU for NUM_SLICES clock slices. Each slice raises clkreq when its agents need a clock, holds it through an idle hysteresis window, and drops it once the window expires. It also owns per-slice reset release: slice_rst_b deasserts a fixed delay after the first clock grant. The block sits between the slice wake logic and the CCU, and is verified against the ccu_vc agent.

Parameters:
NUM_SLICES, 7, number of independent clock slices
HYST_CYC, 16, idle cycles in HYST before clkreq drops (0 = no hysteresis)
ACK_TIMEOUT, 64, cycles waiting for a clkack edge before err_timeout sets
RST_DLY, 8, cycles after the first ON entry before slice_rst_b releases
SYNC_STAGES, 2, flop stages on each clkack bit

Ports:
clk  in  1  sequencer clock
rst  in  1  asynchronous, active-high reset
wake  in  NUM_SLICES  per-slice level: slice needs its clock
clkack  in  NUM_SLICES  CCU acknowledge, asynchronous to clk
clkreq  out  NUM_SLICES  clock request to CCU, registered
clk_on  out  NUM_SLICES  slice clock is guaranteed running, registered
slice_rst_b  out  NUM_SLICES  per-slice active-low reset, registered
err_timeout  out  NUM_SLICES  sticky handshake-timeout flag

Behaviour:
- Reset (async assert, sync deassert): state=OFF; clkreq=0, clk_on=0, slice_rst_b=0, err_timeout=0; timers=0; sync flops=0.
- ack_s = clkack after SYNC_STAGES flops; all FSM decisions use ack_s only.
- Slices are fully independent. There is no arbitration between slices.
- clkreq and clk_on come from dedicated flops and are loaded with the next-state decode. They never come from combinational decode.
- States:
  - OFF: clkreq=0, clk_on=0. If wake && !ack_s -> REQ_UP. If wake && ack_s (stale ack), stay in OFF.
  - REQ_UP: clkreq=1. On ack_s=1 -> ON. Timer counts each cycle; when it reaches ACK_TIMEOUT, set err_timeout and stay in REQ_UP with clkreq held at 1.
  - ON: clkreq=1, clk_on=1. On !wake -> HYST (load hyst counter = HYST_CYC), or -> REQ_DN directly if HYST_CYC=0.
  - HYST: clkreq=1, clk_on=1. Hyst counter decrements. If wake -> ON (counter cleared). If counter==1 && !wake -> REQ_DN.
  - REQ_DN: clkreq=0, clk_on=0. On ack_s=0 -> OFF. A wake seen here is ignored until the handshake completes (four-phase rule: clkreq never re-rises while ack_s=1). Timeout as in REQ_UP: err set, stay in REQ_DN.
- Latency, wake to clock on:
  - wake sampled at cycle 0 in OFF -> clkreq=1 at cycle 1.
  - clkack rising at cycle k -> ack_s at k+SYNC_STAGES -> clk_on=1 one cycle later.
- Hysteresis: with !wake from ON at cycle 0, clkreq falls at cycle HYST_CYC+1.
- Timers: width $clog2(max(ACK_TIMEOUT,HYST_CYC,RST_DLY)+1). They saturate and never wrap. The ack timer clears on every state change.
- err_timeout is sticky and is cleared only by rst. A late ack after timeout still advances the FSM normally.
- slice_rst_b:
  - Stays 0 until the first entry into ON; then a counter runs RST_DLY cycles and slice_rst_b goes to 1.
  - Stays 1 through later OFF/ON cycles until rst.
  - If the slice leaves ON before the count completes, the counter freezes and resumes on the next ON.
- Simultaneous wake deassert and ack_s rise in REQ_UP: go to ON first; HYST is entered on the next cycle.
- rst asserted mid-handshake: clkreq drops to 0 immediately (async). After reset the FSM starts in OFF and waits for ack_s=0 before any new request.

Decomposition:
- Package ccu_clkreq_pkg: typedef enum logic [2:0] ccu_clkreq_state_t {OFF, REQ_UP, ON, HYST, REQ_DN}; default constants for HYST_CYC, ACK_TIMEOUT, RST_DLY, SYNC_STAGES.
- Sub-module ccu_clkreq_slice_fsm: one slice (synchronizer, FSM, three timers, output flops).
- Top level is a generate loop of NUM_SLICES instances.

Test Plan:
1. Wake slice 0 at cycle 10; agent acks 3 cycles after clkreq -> clkreq[0]=1 @11; clk_on[0]=1 @17; slice_rst_b[0]=1 @25.
2. In ON, drop wake for 10 cycles then reassert -> clkreq stays 1, state returns to ON, no clkack toggle. Drop wake for 20 cycles -> clkreq falls 17 cycles after the drop, clk_on falls with it.
3. In REQ_DN with agent delaying ack fall by 30 cycles, assert wake -> clkreq stays 0 until ack_s=0, enters OFF, re-rises the cycle after. No clkreq=1 while ack_s=1.
4. Agent never acks slice 3 -> err_timeout[3]=1 exactly 64 cycles after REQ_UP entry. Clkreq[3] held at 1. A late ack at cycle 200 -> clk_on[3]=1; err stays 1.
5. All 7 slices woken in the same cycle with random ack delays 1..40 -> each slice completes independently; per-slice latencies match rule 1; no cross-slice interaction.
6. Assert rst while slice 2 is in HYST and slice 5 is in REQ_UP -> all outputs 0 within the same time step. After release with clkack still 1, the FSM holds OFF until ack falls.
